btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised branch target buffer for the RISC-V fetch/execute loop.
- Set count, associativity (1 or 2 ways), tag width and perf-counter width are configurable.
- Stores full word-aligned targets and uses LRU replacement in 2-way mode.
- Looks up the fetch PC combinationally to produce a predicted next PC.
- Trains on resolved branches from the execute stage and raises flush/redirect on misprediction.
- Adds saturating branch and misprediction performance counters.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2; IDX_W = clog2(SETS).
- WAYS, 2, associativity; legal values 1 or 2.
- TAG_W, 8, tag bits taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2]; IDX_W+2+TAG_W ≤ 32.
- CNT_W, 16, width of each perf counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- stall  in  1  pipeline/memory stall; blocks all state updates.
- pc_f  in  32  fetch-stage PC to predict.
- pc_x  in  32  PC of the instruction resolving in execute.
- is_branch_x  in  1  execute instruction is a branch/jump.
- taken_x  in  1  actual outcome.
- target_x  in  32  actual taken target.
- pred_taken_x  in  1  prediction made for this instruction at fetch (carried down the pipeline).
- pred_target_x  in  32  predicted target carried down the pipeline.
- pred_taken  out  1  fetch prediction.
- next_pc  out  32  next fetch PC.
- flush  out  1  misprediction; squash younger instructions.
- perf_branches  out  CNT_W  resolved branch count.
- perf_mispredicts  out  CNT_W  misprediction count.

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk.
  - All valid bits, tags, targets, counters and LRU bits clear to 0; both perf counters clear to 0.
  - After reset, pred_taken=0 and next_pc=pc_f+4. flush=0 unless a branch is resolving.
- Entry contents: valid, tag[TAG_W], target[31:2] (30 bits; target[1:0] is implied 0), ctr[1:0]. In 2-way mode there is also one LRU bit per set, holding the index of the least-recently-used way.
- Lookup (combinational, reads registered state only):
  - Index = pc_f[IDX_W+1:2]; hit when a way's valid=1 and its tag matches.
  - If multiple ways match, the lowest way wins.
  - pred_taken = hit & ctr[1].
  - Lookup never modifies LRU.
- Mispredict (combinational): mis = is_branch_x & ((pred_taken_x != taken_x) | (taken_x & pred_taken_x & pred_target_x != target_x)).
- next_pc / flush:
  - If mis: flush=1 and next_pc = taken_x ? target_x : pc_x+4. This has priority over the fetch prediction.
  - Else if pred_taken: next_pc = {stored target, 2'b00}.
  - Else: next_pc = pc_f+4.
  - flush and next_pc are asserted even during stall. The consumer gates them.
- Training happens at posedge when !stall & is_branch_x; the set is indexed by pc_x.
  - Hit, taken_x=1, stored target != target_x[31:2]: write the target and set ctr=2'b10.
  - Hit, otherwise: 2-bit saturating counter update (taken increments to max 3, not-taken decrements to min 0); target unchanged.
  - Miss, taken_x=1: allocate the lowest-index invalid way, or the LRU way if all are valid. Write valid=1, tag, target, ctr=2'b10.
  - Miss, taken_x=0: no allocation and no LRU change.
  - Any hit or allocation sets the LRU bit to point at the other way. WAYS=1 has no LRU.
- Perf counters, updated at posedge when !stall:
  - perf_branches increments if is_branch_x.
  - perf_mispredicts increments if mis.
  - Both saturate at all-ones and never wrap.
- Read/write ordering: when pc_f and pc_x index the same set in the same cycle, the lookup sees pre-update contents; the update is visible the next cycle.
- Mid-operation rst_n low overrides training and counter increments in that cycle.

Test Plan:
- Reset, then pc_f=0x40 -> pred_taken=0, next_pc=0x44, flush=0, both perf counters 0.
- Cold branch: pc_x=0x40, taken_x=1, target_x=0x100, pred_taken_x=0 -> flush=1 and next_pc=0x100 that cycle. Next cycle pc_f=0x40 -> pred_taken=1, next_pc=0x100 (ctr=10); perf_mispredicts=1.
- Saturation/hysteresis on 0x40: two taken then one not-taken (ctr 10->11->11->10) -> still predicts taken. A second not-taken (ctr 01) -> next_pc=0x44.
- Target change: entry 0x40->0x100 hit; resolve with taken_x=1, pred_target_x=0x100, target_x=0x180 -> flush=1, next_pc=0x180; next lookup yields 0x180.
- LRU, SETS=8, WAYS=2: allocate taken branches at 0x40, then 0x440 (same set, different tag), then retrain 0x40, then allocate 0x840 -> 0x440 evicted, 0x40 and 0x840 both hit. With WAYS=1 only 0x840 hits.
- Stall: mispredicting branch presented with stall=1 -> flush=1 shown, but no table change and no perf increments. Counters pinned at 2^CNT_W-1 do not wrap.

Source files
------------

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module   : btb_assoc
// Brief    : Set-associative branch target buffer (1 or 2 ways, LRU) with
//            2-bit counters, mispredict redirect and saturating perf counters.
// Revision : 1.0
// ============================================================================
module btb_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [31:0]      pc_f,
    input  logic [31:0]      pc_x,
    input  logic             is_branch_x,
    input  logic             taken_x,
    input  logic [31:0]      target_x,
    input  logic             pred_taken_x,
    input  logic [31:0]      pred_target_x,
    output logic             pred_taken,
    output logic [31:0]      next_pc,
    output logic             flush,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_LO = c_IDX_W + 2;

    logic               r_valid  [WAYS][SETS];
    logic [TAG_W-1:0]   r_tag    [WAYS][SETS];
    logic [29:0]        r_target [WAYS][SETS];
    logic [1:0]         r_ctr    [WAYS][SETS];
    logic [CNT_W-1:0]   r_perf_br;
    logic [CNT_W-1:0]   r_perf_mis;

    logic [c_IDX_W-1:0] w_idx_f, w_idx_x;
    logic [TAG_W-1:0]   w_tag_f, w_tag_x;
    logic               w_hit_f;
    logic [1:0]         w_ctr_f;
    logic [29:0]        w_tgt_f;
    logic               w_mis;
    logic               w_train;
    logic [WAYS-1:0]    w_hit_oh_x;
    logic               w_hit_any_x;
    logic [WAYS-1:0]    w_alloc_oh;
    logic [WAYS-1:0]    w_use_oh;
    logic               w_used_way;
    logic               w_victim_way;
    logic               w_found;
    logic               w_unused;

    assign w_idx_f = pc_f[c_IDX_W+1:2];
    assign w_idx_x = pc_x[c_IDX_W+1:2];
    assign w_tag_f = pc_f[c_TAG_LO+TAG_W-1:c_TAG_LO];
    assign w_tag_x = pc_x[c_TAG_LO+TAG_W-1:c_TAG_LO];
    assign w_unused = ^{pc_f, pc_x, target_x[1:0]};

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        w_hit_f = 1'b0;
        w_ctr_f = 2'b00;
        w_tgt_f = 30'd0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w][w_idx_f] && (r_tag[w][w_idx_f] == w_tag_f)) begin
                w_hit_f = 1'b1;
                w_ctr_f = r_ctr[w][w_idx_f];
                w_tgt_f = r_target[w][w_idx_f];
            end
        end
    end

    assign pred_taken = w_hit_f & w_ctr_f[1];
    assign w_mis = is_branch_x & ((pred_taken_x != taken_x) |
                   (taken_x & pred_taken_x & (pred_target_x != target_x)));

    always_comb begin
        flush   = 1'b0;
        next_pc = pc_f + 32'd4;
        if (w_mis) begin
            flush   = 1'b1;
            next_pc = taken_x ? target_x : (pc_x + 32'd4);
        end else if (pred_taken) begin
            next_pc = {w_tgt_f, 2'b00};
        end
    end

    // Training side: one-hot hit (lowest way) and allocation victim.
    always_comb begin
        w_hit_oh_x  = '0;
        w_hit_any_x = 1'b0;
        w_alloc_oh  = '0;
        w_found     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit_any_x && r_valid[w][w_idx_x] && (r_tag[w][w_idx_x] == w_tag_x)) begin
                w_hit_oh_x[w] = 1'b1;
                w_hit_any_x   = 1'b1;
            end
            if (!w_found && !r_valid[w][w_idx_x]) begin
                w_alloc_oh[w] = 1'b1;
                w_found       = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                w_alloc_oh[w] = (w == int'(w_victim_way));
            end
        end
    end

    assign w_use_oh = w_hit_any_x ? w_hit_oh_x : w_alloc_oh;

    always_comb begin
        w_used_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_use_oh[w]) w_used_way = (w != 0);
        end
    end

    assign w_train = !stall && is_branch_x;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s]  <= 1'b0;
                    r_tag[w][s]    <= '0;
                    r_target[w][s] <= '0;
                    r_ctr[w][s]    <= 2'b00;
                end
            end
        end else if (w_train) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_hit_oh_x[w]) begin
                    if (taken_x && (r_target[w][w_idx_x] != target_x[31:2])) begin
                        r_target[w][w_idx_x] <= target_x[31:2];
                        r_ctr[w][w_idx_x]    <= 2'b10;
                    end else if (taken_x) begin
                        if (r_ctr[w][w_idx_x] != 2'b11)
                            r_ctr[w][w_idx_x] <= r_ctr[w][w_idx_x] + 2'b01;
                    end else begin
                        if (r_ctr[w][w_idx_x] != 2'b00)
                            r_ctr[w][w_idx_x] <= r_ctr[w][w_idx_x] - 2'b01;
                    end
                end else if (!w_hit_any_x && taken_x && w_alloc_oh[w]) begin
                    r_valid[w][w_idx_x]  <= 1'b1;
                    r_tag[w][w_idx_x]    <= w_tag_x;
                    r_target[w][w_idx_x] <= target_x[31:2];
                    r_ctr[w][w_idx_x]    <= 2'b10;
                end
            end
        end
    end

    generate
        if (WAYS == 2) begin : g_lru
            logic r_lru [SETS];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) r_lru[s] <= 1'b0;
                end else if (w_train && (w_hit_any_x || taken_x)) begin
                    r_lru[w_idx_x] <= ~w_used_way;
                end
            end
            assign w_victim_way = r_lru[w_idx_x];
        end else begin : g_no_lru
            logic w_unused_way;
            assign w_unused_way = w_used_way;
            assign w_victim_way = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_br  <= '0;
            r_perf_mis <= '0;
        end else if (!stall) begin
            if (is_branch_x && (r_perf_br != {CNT_W{1'b1}}))
                r_perf_br <= r_perf_br + 1'b1;
            if (w_mis && (r_perf_mis != {CNT_W{1'b1}}))
                r_perf_mis <= r_perf_mis + 1'b1;
        end
    end

    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mis;

endmodule
`default_nettype wire
